// File: rtl/synapse_scheduler.sv
// synapse_scheduler
//   Walks the weight matrix of the ONN row by row and produces one signed
//   coupling sum per neuron:
//     sum[r] = sum over c != r of w[r][c] * s[c]
//   where s[c] = +1 when phase bit c is set and -1 otherwise. The phase
//   states are captured once, on start, and stay fixed for the whole pass.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            single-cycle pass request (honoured only in IDLE)
//   phase_state      neuron states, bit c = 1 -> +1, 0 -> -1
//   weight_addr_row  row address to the combinational weight memory
//   weight_addr_col  column address to the combinational weight memory
//   weight           signed weight for the current address
//   sum_valid/ready  handshake for each row sum
//   sum_row          neuron index of the presented sum
//   sum_data         signed coupling sum
//   busy             high while a pass is in progress, including done cycle
//   done             one-cycle pulse after the last sum is accepted
module synapse_scheduler #(
    parameter int NUM_NEURONS  = 15,
    parameter int WEIGHT_WIDTH = 5,
    parameter int ADDR_WIDTH   = 4,
    parameter int ACC_WIDTH    = WEIGHT_WIDTH + 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_NEURONS-1:0]  phase_state,
    output logic [ADDR_WIDTH-1:0]   weight_addr_row,
    output logic [ADDR_WIDTH-1:0]   weight_addr_col,
    input  logic [WEIGHT_WIDTH-1:0] weight,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic [ADDR_WIDTH-1:0]   sum_row,
    output logic [ACC_WIDTH-1:0]    sum_data,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_NEURONS - 1);

    logic [1:0]             state;
    logic [ADDR_WIDTH-1:0]  row;
    logic [ADDR_WIDTH-1:0]  col;
    logic [ACC_WIDTH-1:0]   acc;
    logic [NUM_NEURONS-1:0] snap;

    logic [ACC_WIDTH-1:0]   w_ext;
    logic [ACC_WIDTH-1:0]   term;
    logic [ACC_WIDTH-1:0]   acc_next;

    // Addresses are live in ACCUM and EMIT (EMIT keeps the last column);
    // forced to zero otherwise so reset clears them asynchronously.
    assign weight_addr_row = (state == ACCUM || state == EMIT) ? row : '0;
    assign weight_addr_col = (state == ACCUM || state == EMIT) ? col : '0;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

    always_comb begin
        w_ext = {{(ACC_WIDTH-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
        term  = '0;
        // Self-coupling is excluded whatever the memory holds on the diagonal.
        if (col != row) begin
            term = snap[col] ? w_ext : -w_ext;
        end
        acc_next = acc + term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            acc       <= '0;
            snap      <= '0;
            sum_valid <= 1'b0;
            sum_row   <= '0;
            sum_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap  <= phase_state;
                        row   <= '0;
                        col   <= '0;
                        acc   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (col == LAST) begin
                        sum_data  <= acc_next;
                        sum_row   <= row;
                        sum_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        acc <= acc_next;
                        col <= col + ADDR_WIDTH'(1);
                    end
                end
                EMIT: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        if (row == LAST) begin
                            state <= DONE;
                        end else begin
                            row   <= row + ADDR_WIDTH'(1);
                            col   <= '0;
                            acc   <= '0;
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
